riscv_v_pipe_ctrl: RTL and testbench
====================================

RISCV_V_PIPE_CTRL -- requirements
Module: riscv_v_pipe_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, giving the number of controlled stage registers (1..16).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the input-blocking cycles after a flush (1..15).
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream has an item for stage 1.
REQ-006 Port: in_ready  output  1  stage 1 can accept the item this cycle.
REQ-007 Port: stage_hold  input  NUM_STAGES  bit i-1 means stage i content must not advance (hazard).
REQ-008 Port: out_ready  input  1  downstream accepts from stage NUM_STAGES.
REQ-009 Port: out_valid  output  1  stage NUM_STAGES presents a valid item.
REQ-010 Port: flush_req  input  1  kill request, single cycle.
REQ-011 Port: flush_upto  input  $clog2(NUM_STAGES+1)  flush stages 1..flush_upto; 0 means all stages.
REQ-012 Port: stage_en  output  NUM_STAGES  per-stage register enable.
REQ-013 Port: stage_flush  output  NUM_STAGES  per-stage register flush, loads flush value.
REQ-014 Port: stage_valid  output  NUM_STAGES  registered per-stage valid bits.

Function
REQ-015 Notation: v[i]=stage_valid[i-1]; h[i]=stage_hold[i-1]; v[0]=in_valid; h[0]=0; room[N+1]=out_ready, where N=NUM_STAGES.
REQ-016 The block SHALL compute combinationally go[i]=v[i]&!h[i]&room[i+1] and room[i]=!v[i]|go[i], for i=N down to 1.
REQ-017 Outside flush, stage_en[i-1] SHALL equal room[i], and v[i] SHALL update to v[i-1]&!h[i-1] when enabled, else hold.
REQ-018 A held stage with a free successor SHALL pass a bubble (v=0) to its successor; it SHALL never duplicate an item.
REQ-019 In RUN, in_ready SHALL equal room[1]; out_valid SHALL equal v[N]&!h[N]; an item transfers when valid&ready.
REQ-020 FSM states SHALL be RUN and FLUSH, with a counter cnt of width 4.
REQ-021 On flush_req in any state, with K=flush_upto (0 treated as N), the block SHALL behave as follows in that cycle:
  - stage_flush[i-1]=1 and stage_en[i-1]=0 for i<=K;
  - v[1..K] clear at the edge;
  - stages i>K follow REQ-017 with v[K] taken as 0;
  - state becomes FLUSH with cnt=FLUSH_CYCLES.
REQ-022 In FLUSH, in_ready SHALL be 0 and stage 1 SHALL load a bubble.
REQ-023 In FLUSH, cnt SHALL decrement each cycle; at cnt==1 the state SHALL return to RUN, giving exactly FLUSH_CYCLES blocked cycles after the flush cycle.
REQ-024 A flush_req during FLUSH SHALL re-apply REQ-021 and reload cnt.
REQ-025 flush SHALL take priority over hold and enable; stage_flush and stage_en SHALL never both be 1 for a stage.
REQ-026 flush_upto>N SHALL be treated as N.

Reset
REQ-027 While rst_n=0, the block SHALL hold stage_valid=0, state=RUN, cnt=0 and all stage_flush=0.
REQ-028 After reset, stage_en SHALL be all ones, out_valid=0, and in_ready=1.
REQ-029 Reset asserted mid-FLUSH or with items in flight SHALL discard all items; no output transfer SHALL occur in the first cycle after release.

Configuration
REQ-030 With macro RISCV_V_PIPE_CTRL_PERF_EN defined, the block SHALL add output stall_cnt (32) counting cycles with in_valid&!in_ready, and output flush_cnt (16) counting flush_req cycles.
REQ-031 Both counters SHALL saturate, reset to 0, and be cleared only by reset.
REQ-032 Without RISCV_V_PIPE_CTRL_PERF_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Streaming: N=4, in_valid=1 every cycle, out_ready=1, no hold -> first out_valid 4 cycles after first accept; then 1 item/cycle, in order.
REQ-034 Backpressure: full pipe, out_ready=0 for 3 cycles -> in_ready=0 and stage_en=0000 for those cycles; no item lost or duplicated on release.
REQ-035 Hold bubble: full pipe, stage_hold=0010 for 1 cycle -> stage 3 receives a bubble; stages 1-2 stall; stage 4 drains; order preserved.
REQ-036 Partial flush: full pipe, flush_req with flush_upto=2 -> stage_flush=0011 that cycle, v[1..2]=0; items in stages 3-4 exit normally; in_ready=0 for exactly 2 following cycles.
REQ-037 Re-flush and reset: flush_req with flush_upto=0, then again 1 cycle later -> blocking extends to 2 cycles after the second flush; rst_n pulsed low mid-FLUSH -> stage_valid=0000, in_ready=1 after release.
REQ-038 Perf build: 5 cycles of in_valid=1 with in_ready=0 plus 2 flush_req cycles -> stall_cnt=5, flush_cnt=2.

Source files
------------

// File: rtl/riscv_v_pipe_ctrl_if.sv
// riscv_v_pipe_ctrl_if: pipeline control bus; master drives requests and hazards, slave returns enables and valids. RISCV_V_PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt.
interface riscv_v_pipe_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  logic in_valid;
  logic in_ready;
  logic out_ready;
  logic out_valid;
  logic flush_req;
  logic [$clog2(NUM_STAGES+1)-1:0] flush_upto;
  logic [NUM_STAGES-1:0] stage_hold;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_flush;
  logic [NUM_STAGES-1:0] stage_valid;
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif
  modport master (
    output in_valid, out_ready, flush_req, flush_upto, stage_hold,
    input in_ready, out_valid, stage_en, stage_flush, stage_valid
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input in_valid, out_ready, flush_req, flush_upto, stage_hold,
    output in_ready, out_valid, stage_en, stage_flush, stage_valid
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/riscv_v_pipe_ctrl.sv
// riscv_v_pipe_ctrl: valid/enable/flush control for a NUM_STAGES pipeline (ports: clk, rst_n, bus slave; RISCV_V_PIPE_CTRL_PERF_EN adds perf counters).
module riscv_v_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  riscv_v_pipe_ctrl_if.slave bus
);
  localparam int N = NUM_STAGES;
  localparam int KW = $clog2(N + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [N-1:0] v, h, room, kill, en, src;
  logic [KW-1:0] k;
  logic flush, run, r, in_ready;
  assign h = bus.stage_hold;
  assign flush = bus.flush_req & rst_n;
  assign run = (state == RUN) & ~flush;
  assign k = (bus.flush_upto == '0 || bus.flush_upto > KW'(N)) ? KW'(N) : bus.flush_upto;
  // room ripples from the output back toward stage 1
  always_comb begin
    r = bus.out_ready;
    room = '0;
    kill = '0;
    src = '0;
    for (int s = N - 1; s >= 0; s--) begin
      r = ~v[s] | (~h[s] & r);
      room[s] = r;
      kill[s] = flush & (s < int'(k));
    end
    src[0] = bus.in_valid & run;
    for (int s = 1; s < N; s++) src[s] = v[s-1] & ~h[s-1] & ~kill[s-1];
  end
  assign en = room & ~kill;
  assign in_ready = room[0] & run;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = v[N-1] & ~h[N-1] & ~kill[N-1];
  assign bus.stage_en = en;
  assign bus.stage_flush = kill;
  assign bus.stage_valid = v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      state <= RUN;
      cnt <= '0;
    end else begin
      v <= (v & ~en & ~kill) | (src & en);
      if (flush) begin
        state <= FLUSH;
        cnt <= 4'(FLUSH_CYCLES);
      end else if (state == FLUSH) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RUN;
      end
    end
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.in_valid & ~in_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush_req & ~&flush_cnt) flush_cnt <= flush_cnt + 16'd1;
    end
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// tb_riscv_v_pipe_ctrl: item-tag reference model with scoreboard queue, directed and random traffic.
module tb_riscv_v_pipe_ctrl;
  localparam int N = 4;
  localparam int FC = 2;
  localparam int KW = $clog2(N + 1);
  typedef struct {
    logic ir;
    logic ov;
    logic [N-1:0] en;
    logic [N-1:0] fl;
    logic [N-1:0] sv;
    int tag;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int in_tag = 0;
  int next_tag = 0;
  int tests = 0;
  int fails = 0;
  int m[N];
  int dp[N];
  logic mfl = 0;
  int mcnt = 0;
  int stalls = 0;
  int flushes = 0;
  exp_t exp_q[$];
  riscv_v_pipe_ctrl_if #(.NUM_STAGES(N)) bus ();
  riscv_v_pipe_ctrl #(.NUM_STAGES(N), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // shadow datapath steered only by the DUT's enables and flushes
  always @(posedge clk) begin
    if (bus.stage_flush[0]) dp[0] <= -1;
    else if (bus.stage_en[0]) dp[0] <= in_tag;
    for (int s = 1; s < N; s++)
      if (bus.stage_flush[s]) dp[s] <= -1;
      else if (bus.stage_en[s]) dp[s] <= dp[s-1];
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
    end
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("in_ready", 32'(bus.in_ready), 32'(e.ir));
      chk("out_valid", 32'(bus.out_valid), 32'(e.ov));
      chk("stage_en", 32'(bus.stage_en), 32'(e.en));
      chk("stage_flush", 32'(bus.stage_flush), 32'(e.fl));
      chk("stage_valid", 32'(bus.stage_valid), 32'(e.sv));
      if (e.tag >= 0) chk("out_tag", dp[N-1], e.tag);
    end
  // one cycle: drive inputs, predict outputs from the item model, advance model at the edge
  task automatic step(input logic iv, input logic [N-1:0] h, input logic oready, input logic fr, input logic [KW-1:0] fu);
    exp_t e;
    int k;
    int nm[N];
    logic [N-1:0] kill, room;
    logic r, run, fa, live;
    live = rst_n;
    bus.in_valid = iv;
    bus.stage_hold = h;
    bus.out_ready = oready;
    bus.flush_req = fr;
    bus.flush_upto = fu;
    in_tag = next_tag;
    fa = fr && live;
    k = (fu == 0 || int'(fu) > N) ? N : int'(fu);
    for (int s = 0; s < N; s++) kill[s] = fa && s < k;
    run = !mfl && !fa;
    r = oready;
    for (int s = N - 1; s >= 0; s--) begin
      r = (m[s] < 0) || (!h[s] && r);
      room[s] = r;
    end
    e.ir = room[0] && run;
    e.ov = m[N-1] >= 0 && !h[N-1] && !kill[N-1];
    e.tag = (e.ov && oready) ? m[N-1] : -1;
    e.en = room & ~kill;
    e.fl = kill;
    for (int s = 0; s < N; s++) e.sv[s] = m[s] >= 0;
    exp_q.push_back(e);
    if (live && iv && !e.ir) stalls++;
    if (live && fr) flushes++;
    for (int s = 0; s < N; s++)
      if (kill[s]) nm[s] = -1;
      else if (!e.en[s]) nm[s] = m[s];
      else if (s == 0) nm[s] = (iv && e.ir) ? next_tag : -1;
      else nm[s] = (m[s-1] >= 0 && !h[s-1] && !kill[s-1]) ? m[s-1] : -1;
    if (iv && e.ir) next_tag++;
    @(posedge clk);
    #1;
    if (live) begin
      m = nm;
      if (fa) begin
        mfl = 1;
        mcnt = FC;
      end else if (mfl) begin
        if (mcnt == 1) mfl = 0;
        mcnt--;
      end
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 0;
    for (int s = 0; s < N; s++) m[s] = -1;
    mfl = 0;
    mcnt = 0;
    stalls = 0;
    flushes = 0;
    repeat (n) step(0, '0, 0, 0, '0);
    rst_n = 1;
  endtask
  initial begin
    bus.in_valid = 0;
    bus.stage_hold = '0;
    bus.out_ready = 0;
    bus.flush_req = 0;
    bus.flush_upto = '0;
    @(posedge clk);
    #1;
    do_reset(2);
    repeat (10) step(1, '0, 1, 0, '0);
    repeat (3) step(1, '0, 0, 0, '0);
    repeat (3) step(1, '0, 1, 0, '0);
    step(1, 4'b0010, 1, 0, '0);
    repeat (3) step(1, '0, 1, 0, '0);
    step(1, '0, 1, 1, 3'd2);
    repeat (4) step(1, '0, 1, 0, '0);
    step(1, '0, 1, 1, 3'd0);
    step(1, '0, 1, 0, '0);
    step(1, '0, 1, 1, 3'd0);
    repeat (4) step(1, '0, 1, 0, '0);
    repeat (4) step(1, '0, 1, 0, '0);
    step(1, '0, 1, 1, 3'd0);
    do_reset(1);
    repeat (3) step(1, '0, 1, 0, '0);
    step(1, '0, 1, 1, 3'd7);
    repeat (3) step(1, '0, 0, 0, '0);
    for (int p = 0; p < 40; p++) begin
      int piv, por, ph, pf;
      piv = $urandom_range(20, 100);
      por = $urandom_range(10, 100);
      ph = $urandom_range(0, 40);
      pf = $urandom_range(0, 10);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
        step($urandom_range(0, 99) < piv,
             ($urandom_range(0, 99) < ph) ? N'($urandom) : '0,
             $urandom_range(0, 99) < por,
             $urandom_range(0, 99) < pf,
             KW'($urandom_range(0, 7)));
      end
    end
    chk("queue_drained", exp_q.size(), 0);
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
    chk("stall_cnt", bus.stall_cnt, stalls);
    chk("flush_cnt", 32'(bus.flush_cnt), flushes);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
